// File: rtl/debug_slave_pkg.sv
// Shared defaults and types for the debug-slave command queue.
// Command entries carry the latched instruction alongside the data-register snapshot.
package debug_slave_pkg;

    localparam int DEF_DR_W        = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_N_CH        = 4;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int LEVEL_W = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_DR_W-1:0] data;
    } cmd_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/debug_slave_sync_edge.sv
// Synchronises a TCK-domain level into clk and emits a registered one-cycle rising-edge pulse.
// Detection stays disarmed for SYNC_STAGES+1 cycles after reset so a level already high is ignored.
module debug_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    localparam int ARM_CNT = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_CNT + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CW-1:0]          arm_cnt;
    logic                   armed;

    assign armed = (arm_cnt == CW'(ARM_CNT));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            arm_cnt <= '0;
            rise    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (!armed)
                arm_cnt <= arm_cnt + 1'b1;
            rise <= armed && sync_q[SYNC_STAGES-1] && !prev_q;
        end
    end

endmodule

// File: rtl/debug_slave_cmd_queue.sv
// Queues virtual-JTAG update-DR commands into clk and decodes each popped entry into action pulses.
// A push into a full queue without a simultaneous pop is dropped and latches overflow.
module debug_slave_cmd_queue
    import debug_slave_pkg::*;
#(
    parameter int DR_W        = DEF_DR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int N_CH        = DEF_N_CH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vs_uir,
    input  logic                        vs_udr,
    input  logic [IR_W-1:0]             ir_in,
    input  logic [DR_W-1:0]             sr,
    input  logic                        cmd_ready,
    input  logic                        ovf_clr,
    output logic                        cmd_valid,
    output logic [IR_W-1:0]             cmd_ir,
    output logic [DR_W-1:0]             cmd_data,
    output logic [DR_W-1:0]             jdo,
    output logic [N_CH-1:0]             take_action,
    output logic [N_CH-1:0]             take_no_action,
    output logic                        ir_err,
    output logic                        overflow,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [IR_W:0] N_CH_L = (IR_W+1)'(N_CH);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } entry_t;

    logic uir_rise;
    logic udr_rise;

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    debug_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    logic [IR_W-1:0] ir_q;
    entry_t          mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    entry_t          head;
    logic            full;
    logic            pop;
    logic            do_push;
    logic            drop;

    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == (AW+1)'(DEPTH));
    assign cmd_valid = (level != '0);
    assign head      = mem[rd_ptr[AW-1:0]];
    assign cmd_ir    = head.ir;
    assign cmd_data  = head.data;
    assign pop       = cmd_valid && cmd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_push   = udr_rise && (!full || pop);
    assign drop      = udr_rise && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= '{ir: ir_q, data: sr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (uir_rise)
                ir_q <= ir_in;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            ir_err         <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            ir_err         <= 1'b0;
            if (pop) begin
                jdo <= head.data;
                if ({1'b0, head.ir} >= N_CH_L) begin
                    ir_err <= 1'b1;
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (head.ir == IR_W'(i)) begin
                            if (head.data[DR_W-1])
                                take_action[i] <= 1'b1;
                            else
                                take_no_action[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_slave_cmd_queue.sv
// Directed bench for debug_slave_cmd_queue built with N_CH=3 so an out-of-range instruction is reachable.
module tb_debug_slave_cmd_queue;

    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int N_CH = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            vs_uir;
    logic            vs_udr;
    logic [IR_W-1:0] ir_in;
    logic [DR_W-1:0] sr;
    logic            cmd_ready;
    logic            ovf_clr;
    logic            cmd_valid;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic [DR_W-1:0] jdo;
    logic [N_CH-1:0] take_action;
    logic [N_CH-1:0] take_no_action;
    logic            ir_err;
    logic            overflow;
    logic [2:0]      level;

    int checks = 0;
    int errors = 0;

    logic [DR_W-1:0] pay [5];
    logic [DR_W-1:0] q   [5];

    always #5 clk = ~clk;

    debug_slave_cmd_queue #(.N_CH(N_CH)) dut (
        .clk            (clk),
        .reset          (reset),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_err         (ir_err),
        .overflow       (overflow),
        .level          (level)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [IR_W-1:0] code);
        ir_in  = code;
        vs_uir = 1'b1;
        step(6);
        vs_uir = 1'b0;
        step(4);
    endtask

    // Push lands on the 4th edge after vs_udr rises; sr held throughout.
    task automatic push_dr(input logic [DR_W-1:0] data);
        sr     = data;
        vs_udr = 1'b1;
        step(5);
        vs_udr = 1'b0;
        step(4);
    endtask

    task automatic pop_one(input string tag, input logic [DR_W-1:0] exp, input logic [N_CH-1:0] act_exp,
                           input logic [N_CH-1:0] nact_exp);
        check({tag, "_head"}, 64'(cmd_data), 64'(exp));
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check({tag, "_jdo"}, 64'(jdo), 64'(exp));
        check({tag, "_act"}, 64'(take_action), 64'(act_exp));
        check({tag, "_nact"}, 64'(take_no_action), 64'(nact_exp));
    endtask

    initial begin
        pay[0] = 38'h20_0000_0001;
        pay[1] = 38'h00_0000_0002;
        pay[2] = 38'h3F_0000_0003;
        pay[3] = 38'h1F_FFFF_FFFF;
        pay[4] = 38'h20_DEAD_BEEF;
        q[0]   = 38'h00_1111_0000;
        q[1]   = 38'h21_2222_0000;
        q[2]   = 38'h02_3333_0000;
        q[3]   = 38'h23_4444_0000;
        q[4]   = 38'h24_5555_0000;

        reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        step(4);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_pulses", 64'({take_action, take_no_action, ir_err}), 64'd0);
        check("rst_jdo", 64'(jdo), 64'd0);
        reset = 1'b0;
        step(6);

        // Single command, consumer always ready: latency and action decode.
        load_ir(2'd2);
        cmd_ready = 1'b1;
        sr        = 38'h20_0000_00AB;
        vs_udr    = 1'b1;
        step(3);
        check("lat_edge3", 64'(cmd_valid), 64'd0);
        step(1);
        check("lat_edge4", 64'(cmd_valid), 64'd1);
        check("lat_ir", 64'(cmd_ir), 64'd2);
        step(1);
        check("act_pulse", 64'(take_action), 64'b100);
        check("act_nact", 64'(take_no_action), 64'd0);
        check("act_jdo", 64'(jdo), 64'h20_0000_00AB);
        check("act_drained", 64'(cmd_valid), 64'd0);
        step(1);
        check("act_one_cycle", 64'(take_action), 64'd0);
        vs_udr    = 1'b0;
        cmd_ready = 1'b0;
        step(4);

        // Five pushes into a four-deep queue.
        for (int i = 0; i < 5; i++) push_dr(pay[i]);
        check("ovf_level", 64'(level), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++)
            pop_one($sformatf("ovf_pop%0d", i), pay[i],
                    pay[i][DR_W-1] ? 3'b100 : 3'b000, pay[i][DR_W-1] ? 3'b000 : 3'b100);
        check("ovf_empty", 64'(cmd_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full queue with a pop coinciding with the push edge.
        for (int i = 0; i < 4; i++) push_dr(q[i]);
        check("full_level", 64'(level), 64'd4);
        sr     = q[4];
        vs_udr = 1'b1;
        step(3);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("pp_level", 64'(level), 64'd4);
        check("pp_ovf", 64'(overflow), 64'd0);
        check("pp_jdo", 64'(jdo), 64'(q[0]));
        vs_udr = 1'b0;
        step(4);
        for (int i = 1; i < 5; i++)
            pop_one($sformatf("pp_pop%0d", i), q[i],
                    q[i][DR_W-1] ? 3'b100 : 3'b000, q[i][DR_W-1] ? 3'b000 : 3'b100);
        check("pp_empty", 64'(level), 64'd0);

        // Out-of-range instruction.
        load_ir(2'd3);
        push_dr(38'h20_0000_0C0D);
        check("err_ir", 64'(cmd_ir), 64'd3);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("err_pulse", 64'(ir_err), 64'd1);
        check("err_no_take", 64'({take_action, take_no_action}), 64'd0);
        check("err_jdo", 64'(jdo), 64'h20_0000_0C0D);
        step(1);
        check("err_one_cycle", 64'(ir_err), 64'd0);

        // Simultaneous update-IR and update-DR: push carries the old instruction.
        ir_in  = 2'd1;
        sr     = 38'h00_0000_0055;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        step(6);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        step(4);
        check("same_old_ir", 64'(cmd_ir), 64'd3);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        push_dr(38'h00_0000_0066);
        check("same_new_ir", 64'(cmd_ir), 64'd1);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("same_nact", 64'(take_no_action), 64'b010);

        // Reset with two entries queued and a pop just taken.
        push_dr(38'h20_0000_0077);
        push_dr(38'h20_0000_0088);
        check("rmid_level", 64'(level), 64'd2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        reset     = 1'b1;
        step(1);
        check("rmid_level0", 64'(level), 64'd0);
        check("rmid_valid0", 64'(cmd_valid), 64'd0);
        check("rmid_pulses", 64'({take_action, take_no_action, ir_err}), 64'd0);

        // Levels held high through reset release must not count as edges.
        ir_in  = 2'd2;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        sr     = 38'h20_0000_0099;
        step(3);
        reset = 1'b0;
        step(10);
        check("hold_level", 64'(level), 64'd0);
        check("hold_valid", 64'(cmd_valid), 64'd0);
        vs_udr = 1'b0;
        step(4);
        push_dr(38'h20_0000_00AA);
        check("hold_push", 64'(level), 64'd1);
        check("hold_ir", 64'(cmd_ir), 64'd0);
        check("hold_data", 64'(cmd_data), 64'h20_0000_00AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
